// File: rtl/multicycle_control.sv
// Multicycle instruction sequencer (IDLE/FETCH/DECODE/EXEC/MEM/WB/ERR) with ack timeouts.
// Define MULTICYCLE_CTRL_SUBWORD_EN to also accept lb/lh/sb/sh alongside lw/sw.
module multicycle_control #(
    parameter int OP_W = 6,
    parameter int TO_W = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [OP_W-1:0] op_i,
    input  logic            stall_i,
    input  logic            imem_ack_i,
    input  logic            dmem_ack_i,
    output logic [2:0]      state_o,
    output logic            pc_write_o,
    output logic            ir_write_o,
    output logic            jump_o,
    output logic            branch_o,
    output logic            reg_write_o,
    output logic            mem_to_reg_o,
    output logic            alu_src_o,
    output logic            reg_dst_o,
    output logic [1:0]      mem_read_o,
    output logic [1:0]      mem_write_o,
    output logic [1:0]      alu_op_o,
    output logic            err_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERR    = 3'd6
    } state_e;

    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
`ifdef MULTICYCLE_CTRL_SUBWORD_EN
    localparam logic [OP_W-1:0] OP_LB   = OP_W'(6'b100000);
    localparam logic [OP_W-1:0] OP_LH   = OP_W'(6'b100001);
    localparam logic [OP_W-1:0] OP_SB   = OP_W'(6'b101000);
    localparam logic [OP_W-1:0] OP_SH   = OP_W'(6'b101001);
`endif
    localparam logic [TO_W-1:0] TO_MAX  = '1;

    state_e          state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;

    // Access code doubles as the load/store class: nonzero means memory op.
    function automatic logic [1:0] ld_code(input logic [OP_W-1:0] op);
        ld_code = 2'd0;
        if (op == OP_LW) ld_code = 2'd3;
`ifdef MULTICYCLE_CTRL_SUBWORD_EN
        if (op == OP_LB) ld_code = 2'd1;
        if (op == OP_LH) ld_code = 2'd2;
`endif
    endfunction

    function automatic logic [1:0] st_code(input logic [OP_W-1:0] op);
        st_code = 2'd0;
        if (op == OP_SW) st_code = 2'd3;
`ifdef MULTICYCLE_CTRL_SUBWORD_EN
        if (op == OP_SB) st_code = 2'd1;
        if (op == OP_SH) st_code = 2'd2;
`endif
    endfunction

    logic       is_r, is_addi, is_beq, is_j, is_ld, is_st, is_mem, op_i_legal;
    logic [1:0] ld_c, st_c, alu_op_v;

    assign ld_c     = ld_code(op_q);
    assign st_c     = st_code(op_q);
    assign is_r     = (op_q == OP_R);
    assign is_addi  = (op_q == OP_ADDI);
    assign is_beq   = (op_q == OP_BEQ);
    assign is_j     = (op_q == OP_J);
    assign is_ld    = (ld_c != 2'd0);
    assign is_st    = (st_c != 2'd0);
    assign is_mem   = is_ld | is_st;
    assign alu_op_v = is_r ? 2'd1 : is_addi ? 2'd2 : is_mem ? 2'd3 : 2'd0;

    assign op_i_legal = (op_i == OP_R) | (op_i == OP_ADDI) | (op_i == OP_BEQ) |
                        (op_i == OP_J) | (ld_code(op_i) != 2'd0) | (st_code(op_i) != 2'd0);

    // Saturating wait count; reaching TO_MAX without an ack is the timeout.
    assign cnt_inc = (cnt_q == TO_MAX) ? cnt_q : cnt_q + TO_W'(1);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        pc_write_o   = 1'b0;
        ir_write_o   = 1'b0;
        jump_o       = 1'b0;
        branch_o     = 1'b0;
        reg_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_src_o    = 1'b0;
        reg_dst_o    = 1'b0;
        mem_read_o   = 2'd0;
        mem_write_o  = 2'd0;
        alu_op_o     = 2'd0;
        err_o        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                end
            end
            S_FETCH: begin
                // IR/PC strobes fire only in the cycle the fetch completes.
                ir_write_o = imem_ack_i;
                pc_write_o = imem_ack_i;
                if (imem_ack_i) begin
                    state_d = S_DECODE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TO_MAX) state_d = S_ERR;
                end
            end
            S_DECODE: begin
                if (!stall_i) begin
                    op_d    = op_i;
                    state_d = op_i_legal ? S_EXEC : S_ERR;
                end
            end
            S_EXEC: begin
                alu_op_o  = alu_op_v;
                alu_src_o = is_addi | is_mem;
                reg_dst_o = is_r;
                branch_o  = is_beq;
                jump_o    = is_j;
                pc_write_o = is_beq | is_j;
                if (is_r | is_addi) begin
                    state_d = S_WB;
                end else if (is_mem) begin
                    state_d = S_MEM;
                    cnt_d   = '0;
                end else begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                end
            end
            S_MEM: begin
                alu_op_o    = alu_op_v;
                alu_src_o   = 1'b1;
                mem_read_o  = ld_c;
                mem_write_o = st_c;
                if (dmem_ack_i) begin
                    state_d = is_ld ? S_WB : S_FETCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TO_MAX) state_d = S_ERR;
                end
            end
            S_WB: begin
                alu_op_o     = alu_op_v;
                alu_src_o    = is_addi | is_mem;
                reg_dst_o    = is_r;
                reg_write_o  = 1'b1;
                mem_to_reg_o = is_ld;
                state_d      = S_FETCH;
                cnt_d        = '0;
            end
            S_ERR: begin
                err_o = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-instruction expected traces built from the
// instruction-class rules, plus a narrow-timeout instance for the fetch timeout cases.
module tb_multicycle_control;

    localparam int TOM = 15;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       start_i = 1'b0, stall_i = 1'b0, imem_ack_i = 1'b0, dmem_ack_i = 1'b0;
    logic [5:0] op_i = '0;

    logic [2:0] state_o, state_2;
    logic       pc_write_o, ir_write_o, jump_o, branch_o, reg_write_o, mem_to_reg_o;
    logic       alu_src_o, reg_dst_o, err_o;
    logic [1:0] mem_read_o, mem_write_o, alu_op_o;
    logic       pcw_2, irw_2, jmp_2, br_2, rw_2, m2r_2, asrc_2, rdst_2, err_2;
    logic [1:0] mrd_2, mwr_2, aop_2;

    typedef struct packed {
        logic [2:0] st;
        logic       pcw, irw, jmp, br, rw, m2r, asrc, rdst;
        logic [1:0] mrd, mwr, aop;
        logic       err;
    } obs_t;

    typedef struct packed {
        logic       ia, da, stl, sti;
        logic [5:0] op;
        obs_t       e;
    } cyc_t;

    obs_t obs, obs2;
    cyc_t tr[$];
    int   n_chk = 0, n_pass = 0;

    always #5 clk_i = ~clk_i;

    multicycle_control dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i), .stall_i(stall_i),
        .imem_ack_i(imem_ack_i), .dmem_ack_i(dmem_ack_i), .state_o(state_o),
        .pc_write_o(pc_write_o), .ir_write_o(ir_write_o), .jump_o(jump_o),
        .branch_o(branch_o), .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o),
        .alu_src_o(alu_src_o), .reg_dst_o(reg_dst_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .alu_op_o(alu_op_o), .err_o(err_o)
    );

    multicycle_control #(.TO_W(2)) dut_to (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i), .stall_i(stall_i),
        .imem_ack_i(imem_ack_i), .dmem_ack_i(dmem_ack_i), .state_o(state_2),
        .pc_write_o(pcw_2), .ir_write_o(irw_2), .jump_o(jmp_2), .branch_o(br_2),
        .reg_write_o(rw_2), .mem_to_reg_o(m2r_2), .alu_src_o(asrc_2), .reg_dst_o(rdst_2),
        .mem_read_o(mrd_2), .mem_write_o(mwr_2), .alu_op_o(aop_2), .err_o(err_2)
    );

    assign obs  = {state_o, pc_write_o, ir_write_o, jump_o, branch_o, reg_write_o,
                   mem_to_reg_o, alu_src_o, reg_dst_o, mem_read_o, mem_write_o, alu_op_o, err_o};
    assign obs2 = {state_2, pcw_2, irw_2, jmp_2, br_2, rw_2, m2r_2, asrc_2, rdst_2,
                   mrd_2, mwr_2, aop_2, err_2};

    function automatic logic [1:0] ld_code(input logic [5:0] op);
        case (op)
            6'b100011: return 2'd3;
`ifdef MULTICYCLE_CTRL_SUBWORD_EN
            6'b100000: return 2'd1;
            6'b100001: return 2'd2;
`endif
            default:   return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] st_code(input logic [5:0] op);
        case (op)
            6'b101011: return 2'd3;
`ifdef MULTICYCLE_CTRL_SUBWORD_EN
            6'b101000: return 2'd1;
            6'b101001: return 2'd2;
`endif
            default:   return 2'd0;
        endcase
    endfunction

    function automatic bit legal(input logic [5:0] op);
        return op == 6'b000000 || op == 6'b001000 || op == 6'b000100 || op == 6'b000010 ||
               ld_code(op) != 2'd0 || st_code(op) != 2'd0;
    endfunction

    function automatic logic [5:0] rand_illegal();
        logic [5:0] op;
        do op = 6'($urandom); while (legal(op));
        return op;
    endfunction

    function automatic obs_t err_exp();
        obs_t e = '0;
        e.st = 3'd6;
        e.err = 1'b1;
        return e;
    endfunction

    function automatic void push_start();
        cyc_t c = '0;
        c.sti = 1'b1;
        c.op  = 6'($urandom);
        tr.push_back(c);
    endfunction

    // Appends the expected cycle-by-cycle trace of one instruction starting in FETCH.
    // fw/mw: wait cycles before the imem/dmem ack, sn: stall cycles in DECODE.
    function automatic bit build_instr(input logic [5:0] op, input int fw, input int sn,
                                       input int mw);
        cyc_t c;
        obs_t a = '0;
        bit r  = (op == 6'b000000), ad = (op == 6'b001000);
        bit bq = (op == 6'b000100), jj = (op == 6'b000010);
        bit ld = (ld_code(op) != 0), sw = (st_code(op) != 0);
        a.aop  = r ? 2'd1 : ad ? 2'd2 : (ld || sw) ? 2'd3 : 2'd0;
        a.asrc = ad || ld || sw;
        a.rdst = r;
        for (int k = 0; k <= fw; k++) begin
            c = '0; c.ia = (k == fw); c.da = 1'($urandom); c.stl = 1'($urandom);
            c.op = 6'($urandom);
            if (k >= TOM) begin c.e = err_exp(); tr.push_back(c); return 1; end
            c.e.st = 3'd1; c.e.pcw = c.ia; c.e.irw = c.ia;
            tr.push_back(c);
        end
        for (int k = 0; k <= sn; k++) begin
            c = '0; c.stl = (k < sn); c.ia = 1'($urandom); c.da = 1'($urandom);
            c.op = c.stl ? 6'($urandom) : op;
            c.e.st = 3'd2;
            tr.push_back(c);
        end
        if (!legal(op)) begin
            for (int k = 0; k < 3; k++) begin
                c = '0; c.sti = 1'b1; c.ia = 1'b1; c.op = 6'($urandom); c.e = err_exp();
                tr.push_back(c);
            end
            return 1;
        end
        c = '0; c.op = 6'($urandom); c.stl = 1'($urandom); c.ia = 1'($urandom);
        c.e = a; c.e.st = 3'd3; c.e.br = bq; c.e.jmp = jj; c.e.pcw = bq || jj;
        tr.push_back(c);
        if (bq || jj) return 0;
        if (ld || sw) begin
            for (int k = 0; k <= mw; k++) begin
                c = '0; c.da = (k == mw); c.op = 6'($urandom); c.stl = 1'($urandom);
                if (k >= TOM) begin c.e = err_exp(); tr.push_back(c); return 1; end
                c.e = a; c.e.st = 3'd4; c.e.mrd = ld_code(op); c.e.mwr = st_code(op);
                tr.push_back(c);
            end
            if (sw) return 0;
        end
        c = '0; c.op = 6'($urandom); c.stl = 1'($urandom);
        c.e = a; c.e.st = 3'd5; c.e.rw = 1'b1; c.e.m2r = ld;
        tr.push_back(c);
        return 0;
    endfunction

    task automatic run_trace(input string tag);
        for (int i = 0; i < tr.size(); i++) begin
            imem_ack_i = tr[i].ia; dmem_ack_i = tr[i].da; stall_i = tr[i].stl;
            start_i = tr[i].sti; op_i = tr[i].op;
            @(negedge clk_i);
            n_chk++;
            if (obs !== tr[i].e)
                $display("FAIL %s cycle %0d: got %05h (state %0d) expected %05h (state %0d)",
                         tag, i, obs, obs.st, tr[i].e, tr[i].e.st);
            else n_pass++;
            @(posedge clk_i); #1;
        end
        tr.delete();
        start_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b0; start_i = 1'b0; stall_i = 1'b0; imem_ack_i = 1'b0; dmem_ack_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        obs_t e;
        rst_i = 1'b0; start_i = 1'b1; imem_ack_i = 1'b1; dmem_ack_i = 1'b1; op_i = 6'b100011;
        repeat (2) begin
            @(negedge clk_i);
            n_chk++;
            if ({obs, obs2} !== '0) $display("FAIL reset_hold: got %05h/%05h expected 0", obs, obs2);
            else n_pass++;
        end
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        n_chk++;
        if (obs !== '0) $display("FAIL reset_release: got %05h expected 0", obs);
        else n_pass++;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(negedge clk_i);
        e = '0; e.st = 3'd1; e.pcw = 1'b1; e.irw = 1'b1;
        n_chk++;
        if (obs !== e) $display("FAIL reset_first_edge: got %05h expected %05h", obs, e);
        else n_pass++;
        @(posedge clk_i); #1;
        do_reset();
        repeat (3) begin
            cyc_t c = '0;
            c.ia = 1'b1; c.da = 1'b1;
            tr.push_back(c);
        end
        run_trace("idle_hold");
    endtask

    task automatic test_rtype();
        do_reset();
        push_start();
        void'(build_instr(6'b000000, 0, 0, 0));
        void'(build_instr(6'b001000, 0, 0, 0));
        void'(build_instr(6'b000000, 1, 0, 0));
        run_trace("rtype_addi");
    endtask

    task automatic test_lw_delay();
        do_reset();
        push_start();
        void'(build_instr(6'b100011, 0, 0, 3));
        void'(build_instr(6'b000000, 0, 0, 0));
        run_trace("lw_delay");
    endtask

    task automatic test_stall_sw();
        do_reset();
        push_start();
        void'(build_instr(6'b101011, 0, 2, 0));
        void'(build_instr(6'b000100, 0, 0, 0));
        run_trace("stall_sw");
    endtask

    task automatic test_branch_jump();
        do_reset();
        push_start();
        void'(build_instr(6'b000100, 2, 1, 0));
        void'(build_instr(6'b000010, 0, 0, 0));
        void'(build_instr(6'b000010, 3, 0, 0));
        run_trace("branch_jump");
    endtask

    task automatic test_subword();
        bit erred;
        do_reset();
        push_start();
        erred = build_instr(6'b100000, 0, 0, 1);
        if (!erred) void'(build_instr(6'b101001, 0, 0, 0));
        run_trace("subword");
    endtask

    task automatic test_mem_timeout();
        do_reset();
        push_start();
        void'(build_instr(6'b100011, TOM - 1, 0, TOM - 1));
        void'(build_instr(6'b100011, 0, 0, TOM + 2));
        run_trace("mem_timeout");
    endtask

    task automatic test_illegal();
        for (int i = 0; i < 3; i++) begin
            do_reset();
            push_start();
            void'(build_instr(rand_illegal(), int'($urandom_range(0, 2)),
                              int'($urandom_range(0, 2)), 0));
            run_trace("illegal_op");
        end
    endtask

    task automatic test_random();
        logic [5:0] ops[$] = '{6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
`ifdef MULTICYCLE_CTRL_SUBWORD_EN
        ops.push_back(6'b100000); ops.push_back(6'b100001);
        ops.push_back(6'b101000); ops.push_back(6'b101001);
`endif
        do_reset();
        push_start();
        for (int i = 0; i < 40; i++)
            void'(build_instr(ops[$urandom_range(0, ops.size() - 1)], int'($urandom_range(0, 4)),
                              int'($urandom_range(0, 2)), int'($urandom_range(0, 4))));
        run_trace("random");
    endtask

    // Narrow instance: TO_MAX = 3, so the third ack-less fetch cycle trips ERR.
    task automatic test_fetch_timeout();
        obs_t e;
        do_reset();
        start_i = 1'b1; @(posedge clk_i); #1; start_i = 1'b0;
        imem_ack_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k >= 3) start_i = 1'b1;
            @(negedge clk_i);
            e = (k < 3) ? obs_t'(19'(1) << 15) : err_exp();
            n_chk++;
            if (obs2 !== e) $display("FAIL fetch_timeout k=%0d: got %05h expected %05h", k, obs2, e);
            else n_pass++;
            @(posedge clk_i); #1;
        end
        do_reset();
        start_i = 1'b1; @(posedge clk_i); #1; start_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            imem_ack_i = (k == 2); stall_i = 1'b1;
            @(negedge clk_i);
            e = '0; e.st = (k < 3) ? 3'd1 : 3'd2; e.irw = (k == 2); e.pcw = (k == 2);
            n_chk++;
            if (obs2 !== e) $display("FAIL fetch_ack_boundary k=%0d: got %05h expected %05h", k, obs2, e);
            else n_pass++;
            @(posedge clk_i); #1;
        end
        stall_i = 1'b0; imem_ack_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        start_i = 1'b1; @(posedge clk_i); #1; start_i = 1'b0;
        imem_ack_i = 1'b1; dmem_ack_i = 1'b0; op_i = 6'b100011;
        repeat (3) begin @(posedge clk_i); #1; end
        @(negedge clk_i);
        n_chk++;
        if (obs.st !== 3'd4 || obs.mrd !== 2'd3)
            $display("FAIL mid_mem_setup: got state %0d mem_read %0d expected 4/3", obs.st, obs.mrd);
        else n_pass++;
        #1 rst_i = 1'b0;
        #1;
        n_chk++;
        if ({obs, obs2} !== '0) $display("FAIL reset_mid_mem: got %05h/%05h expected 0", obs, obs2);
        else n_pass++;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        start_i = 1'b1; @(posedge clk_i); #1; start_i = 1'b0;
        op_i = 6'b000000;
        repeat (3) begin @(posedge clk_i); #1; end
        @(negedge clk_i);
        #1 rst_i = 1'b0;
        #1;
        n_chk++;
        if (obs !== '0) $display("FAIL reset_mid_wb: got %05h expected 0", obs);
        else n_pass++;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_delay();
        test_stall_sw();
        test_branch_jump();
        test_subword();
        test_mem_timeout();
        test_illegal();
        test_random();
        test_fetch_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter OP_W, default 6: opcode width; opcode compares zero-extend to OP_W.
REQ-002 Parameter TO_W, default 4: timeout counter width; TO_MAX = 2^TO_W - 1.
REQ-003 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-low.
REQ-005 start_i  in  1  leave IDLE and begin fetching.
REQ-006 op_i  in  OP_W  opcode of the current instruction register.
REQ-007 stall_i  in  1  hazard hold, honoured only in DECODE.
REQ-008 imem_ack_i  in  1  instruction fetch complete.
REQ-009 dmem_ack_i  in  1  data access complete.
REQ-010 state_o  out  3  current state encoding.
REQ-011 pc_write_o, ir_write_o  out  1 each  PC update / IR load strobes.
REQ-012 jump_o, branch_o, reg_write_o, mem_to_reg_o, alu_src_o, reg_dst_o  out  1 each  datapath controls.
REQ-013 mem_read_o, mem_write_o  out  2 each  access code: 0 none, 1 byte, 2 half, 3 word.
REQ-014 alu_op_o  out  2  0 none/J/branch, 1 R-type, 2 addi, 3 memory add.
REQ-015 err_o  out  1  sticky illegal-opcode or timeout flag.

Function
REQ-016 States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=6; all outputs Moore from state and latched opcode op_q.
REQ-017 IDLE -> FETCH when start_i=1; otherwise hold.
REQ-018 FETCH: on imem_ack_i=1, pulse ir_write_o and pc_write_o in that cycle, go to DECODE.
REQ-019 DECODE: stall_i=1 holds DECODE with every control output 0; stall_i=0 latches op_i into op_q and goes to EXEC, or to ERR if opcode illegal.
REQ-020 Legal opcodes: R 000000, addi 001000, lw 100011, sw 101011, beq 000100, j 000010.
REQ-021 EXEC: R/addi -> WB; lw/sw -> MEM; beq asserts branch_o and pc_write_o for one cycle -> FETCH; j asserts jump_o and pc_write_o for one cycle -> FETCH.
REQ-022 MEM: mem_read_o (lw) or mem_write_o (sw) held at the access code until dmem_ack_i=1; then lw -> WB, sw -> FETCH.
REQ-023 WB: reg_write_o=1 for exactly one cycle; mem_to_reg_o=1 for lw only; -> FETCH.
REQ-024 alu_op_o, alu_src_o, reg_dst_o valid from EXEC through WB of the same instruction; 0 in IDLE, FETCH, DECODE, ERR.
REQ-025 reg_dst_o=1 for R-type only; alu_src_o=1 for addi and all loads/stores.
REQ-026 Timeout counter clears on entry to FETCH or MEM, increments each waiting cycle; reaching TO_MAX without ack -> ERR.
REQ-027 Ack in the same cycle the counter reaches TO_MAX: ack wins, normal transition.
REQ-028 Counter saturates; no wrap-around.
REQ-029 ERR: err_o=1, all other controls 0, exits only by reset; start_i ignored.
REQ-030 Per-instruction latency with zero-wait acks: R/addi 4 cycles, lw 5, sw 4, beq/j 3.

Reset
REQ-031 rst_i=0 immediately forces IDLE, op_q=0, counter=0, err_o=0, every output 0, including mid-MEM or mid-WB.
REQ-032 First transition after rst_i rises occurs on the following clk_i edge.

Configuration
REQ-033 Macro MULTICYCLE_CTRL_SUBWORD_EN defined: lb 100000 and lh 100001 are legal loads (mem_read_o 1 / 2), sb 101000 and sh 101001 are legal stores (mem_write_o 1 / 2), sequencing as lw/sw.
REQ-034 Macro undefined: those four opcodes are illegal -> ERR; only word codes (3) ever appear.

Verification
REQ-035 Reset, start_i=1, op_i=000000, acks tied 1 -> states 1,2,3,5,1; reg_dst_o=1, alu_op_o=1, reg_write_o one cycle in WB.
REQ-036 lw with dmem_ack_i delayed 3 cycles -> mem_read_o=3 for 4 MEM cycles, then WB with mem_to_reg_o=1.
REQ-037 stall_i=1 for 2 cycles in DECODE with op_i=101011 -> DECODE held 3 cycles, controls 0, then sw completes with mem_write_o=3.
REQ-038 TO_W=2, imem_ack_i held 0 -> ERR after 3 waiting cycles, err_o=1; second run with ack on cycle 3 -> DECODE, no error.
REQ-039 op_i=100000 -> MULTICYCLE_CTRL_SUBWORD_EN defined: mem_read_o=1; undefined: ERR, err_o=1.
REQ-040 rst_i=0 asserted during MEM -> all outputs 0 before next clk_i edge, state_o=0.
